// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer <-> datapath handshake: IMEM fetch request/ack, decoder flags
// and the one-cycle datapath write enables.
interface cpu_seq_ctrl_if;
  logic       o_imemReq;
  logic       i_imemAck;
  logic       i_illegal;
  logic [4:0] i_rdAddr;
  logic       o_irWe;
  logic       o_aluEn;
  logic       o_gprWe;
  logic       o_pcWe;
  logic       o_retire;

  // Sequencer side
  modport master (
    output o_imemReq, o_irWe, o_aluEn, o_gprWe, o_pcWe, o_retire,
    input  i_imemAck, i_illegal, i_rdAddr
  );

  // Datapath / IMEM side
  modport slave (
    input  o_imemReq, o_irWe, o_aluEn, o_gprWe, o_pcWe, o_retire,
    output i_imemAck, i_illegal, i_rdAddr
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multicycle sequencer for the RV32 datapath: FETCH/DECODE/EXEC/WB with
// run / single-step / halt debug control, IMEM timeout and illegal-op faults,
// and free-running cycle / retired-instruction counters.
module cpu_seq_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_clearFault,
  cpu_seq_ctrl_if.master     bus,
  output logic               o_halted,
  output logic               o_fault,
  output logic [2:0]         o_state,
  output logic [CNT_W-1:0]   o_cycleCount,
  output logic [CNT_W-1:0]   o_instrCount
);

  localparam int unsigned WAIT_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic              step_flag, step_flag_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

  // State, step flag, fetch wait counter and performance counters
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state     <= S_HALT;
      step_flag <= 1'b0;
      wait_cnt  <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step_flag <= step_flag_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (state inside {S_FETCH, S_DECODE, S_EXEC, S_WB})
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state == S_WB)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Next-state logic; an ack arriving on the last allowed FETCH cycle wins over the timeout
  always_comb begin
    state_nxt     = state;
    step_flag_nxt = step_flag;
    wait_cnt_nxt  = wait_cnt;
    unique case (state)
      S_HALT: begin
        if (i_run || i_step) begin
          state_nxt     = S_FETCH;
          step_flag_nxt = i_step & ~i_run;
        end
      end
      S_FETCH: begin
        if (bus.i_imemAck) begin
          state_nxt    = S_DECODE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt    = S_FAULT;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: state_nxt = bus.i_illegal ? S_FAULT : S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        if (step_flag || !i_run) begin
          state_nxt     = S_HALT;
          step_flag_nxt = 1'b0;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        if (i_clearFault) state_nxt = S_HALT;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  // Strobes decoded from state (IR latch also qualified by the IMEM ack)
  always_comb begin
    bus.o_imemReq = 1'b0;
    bus.o_irWe    = 1'b0;
    bus.o_aluEn   = 1'b0;
    bus.o_gprWe   = 1'b0;
    bus.o_pcWe    = 1'b0;
    bus.o_retire  = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.o_imemReq = 1'b1;
        bus.o_irWe    = bus.i_imemAck;
      end
      S_EXEC: bus.o_aluEn = 1'b1;
      S_WB: begin
        bus.o_pcWe   = 1'b1;
        bus.o_retire = 1'b1;
        bus.o_gprWe  = (bus.i_rdAddr != 5'd0);
      end
      default: ;
    endcase
  end

  assign o_halted     = (state == S_HALT);
  assign o_fault      = (state == S_FAULT);
  assign o_state      = state;
  assign o_cycleCount = cycle_cnt;
  assign o_instrCount = instr_cnt;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: vector table plus hand-written stall,
// timeout, wrap and mid-instruction reset sequences. Counters are 4 bits wide.
module tb_cpu_seq_ctrl;

  logic       i_clock = 1'b0;
  logic       i_resetn;
  logic       i_run, i_step, i_clearFault;
  logic       o_halted, o_fault;
  logic [2:0] o_state;
  logic [3:0] o_cycleCount, o_instrCount;

  cpu_seq_ctrl_if bus();

  cpu_seq_ctrl #(.CNT_W(4), .IMEM_TIMEOUT(16)) dut (
    .i_clock      (i_clock),
    .i_resetn     (i_resetn),
    .i_run        (i_run),
    .i_step       (i_step),
    .i_clearFault (i_clearFault),
    .bus          (bus),
    .o_halted     (o_halted),
    .o_fault      (o_fault),
    .o_state      (o_state),
    .o_cycleCount (o_cycleCount),
    .o_instrCount (o_instrCount)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic       run, step, clr, ack, ill;
    logic [4:0] rd;
    logic [2:0] st;
    logic [5:0] strb;   // {req, irWe, aluEn, gprWe, pcWe, retire}
    logic [3:0] instr, cyc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.o_imemReq, bus.o_irWe, bus.o_aluEn, bus.o_gprWe, bus.o_pcWe, bus.o_retire};
  endfunction

  function automatic void add(input logic run, step, clr, ack, ill, input logic [4:0] rd,
                              input logic [2:0] st, input logic [5:0] strb,
                              input logic [3:0] instr, cyc);
    vecs.push_back('{run, step, clr, ack, ill, rd, st, strb, instr, cyc});
  endfunction

  task automatic apply(input logic run, step, clr, ack, ill, input logic [4:0] rd);
    i_run = run; i_step = step; i_clearFault = clr;
    bus.i_imemAck = ack; bus.i_illegal = ill; bus.i_rdAddr = rd;
  endtask

  initial begin
    int n;
    int r;

    //   run stp clr ack ill rd  st  req/ir/alu/gpr/pc/ret instr cyc
    // free run, three instructions with rd=5, run dropped in the third EXEC
    add(1, 0, 0, 1, 0, 5, 0, 6'b000000, 0, 0);
    add(1, 0, 0, 1, 0, 5, 1, 6'b110000, 0, 0);
    add(1, 0, 0, 1, 0, 5, 2, 6'b000000, 0, 1);
    add(1, 0, 0, 1, 0, 5, 3, 6'b001000, 0, 2);
    add(1, 0, 0, 1, 0, 5, 4, 6'b000111, 0, 3);
    add(1, 0, 0, 1, 0, 5, 1, 6'b110000, 1, 4);
    add(1, 0, 0, 1, 0, 5, 2, 6'b000000, 1, 5);
    add(1, 0, 0, 1, 0, 5, 3, 6'b001000, 1, 6);
    add(1, 0, 0, 1, 0, 5, 4, 6'b000111, 1, 7);
    add(1, 0, 0, 1, 0, 5, 1, 6'b110000, 2, 8);
    add(1, 0, 0, 1, 0, 5, 2, 6'b000000, 2, 9);
    add(0, 0, 0, 1, 0, 5, 3, 6'b001000, 2, 10);
    add(0, 0, 0, 1, 0, 5, 4, 6'b000111, 2, 11);
    add(0, 0, 0, 1, 0, 5, 0, 6'b000000, 3, 12);
    // single step with rd=0: pcWe without gprWe; cycle counter wraps 15->0
    add(0, 1, 0, 0, 0, 0, 0, 6'b000000, 3, 12);
    add(0, 0, 0, 1, 0, 0, 1, 6'b110000, 3, 12);
    add(0, 0, 0, 1, 0, 0, 2, 6'b000000, 3, 13);
    add(0, 0, 0, 1, 0, 0, 3, 6'b001000, 3, 14);
    add(0, 0, 0, 1, 0, 0, 4, 6'b000011, 3, 15);
    add(0, 0, 0, 1, 0, 0, 0, 6'b000000, 4, 0);
    // second step: step ignored in FETCH, illegal op faults, fault ignores run/step
    add(0, 1, 0, 0, 0, 3, 0, 6'b000000, 4, 0);
    add(0, 1, 0, 0, 0, 3, 1, 6'b100000, 4, 0);
    add(0, 0, 0, 1, 0, 3, 1, 6'b110000, 4, 1);
    add(0, 0, 0, 1, 1, 3, 2, 6'b000000, 4, 2);
    add(1, 1, 0, 1, 0, 3, 5, 6'b000000, 4, 3);
    add(0, 0, 1, 0, 0, 3, 5, 6'b000000, 4, 3);
    add(0, 0, 0, 0, 0, 3, 0, 6'b000000, 4, 3);

    // reset with run held high
    i_resetn = 1'b0;
    apply(1, 0, 0, 1, 0, 5);
    tick(); tick();
    chk("reset state", 32'(o_state), 0);
    chk("reset strobes", 32'(strobes()), 0);
    chk("reset halted/fault", {30'b0, o_halted, o_fault}, 2);
    chk("reset counters", {24'b0, o_instrCount, o_cycleCount}, 0);
    i_resetn = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].run, vecs[i].step, vecs[i].clr, vecs[i].ack, vecs[i].ill, vecs[i].rd);
      #1;
      chk($sformatf("vec%0d state", i), 32'(o_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(vecs[i].strb));
      chk($sformatf("vec%0d instrCount", i), 32'(o_instrCount), 32'(vecs[i].instr));
      chk($sformatf("vec%0d cycleCount", i), 32'(o_cycleCount), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d halted/fault", i), {30'b0, o_halted, o_fault},
          {30'b0, vecs[i].st == 3'd0, vecs[i].st == 3'd5});
      tick();
    end

    // IMEM stall: ack on the 6th FETCH cycle, then reset in EXEC
    apply(0, 1, 0, 0, 0, 7);
    tick();
    i_step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.i_imemAck = (i == 5);
      #1;
      chk($sformatf("stall req c%0d", i), 32'(bus.o_imemReq), 1);
      chk($sformatf("stall irWe c%0d", i), 32'(bus.o_irWe), 32'(i == 5));
      tick();
    end
    chk("stall decode", 32'(o_state), 2);
    tick();
    chk("exec before reset", {29'b0, o_state}, 3);
    chk("exec aluEn", 32'(bus.o_aluEn), 1);
    i_resetn = 1'b0;
    #1;
    chk("midop reset state", 32'(o_state), 0);
    chk("midop reset strobes", 32'(strobes()), 0);
    chk("midop reset counters", {24'b0, o_instrCount, o_cycleCount}, 0);
    tick();
    i_resetn = 1'b1;

    // IMEM timeout: 16 request cycles without ack, then fault
    apply(1, 0, 0, 0, 0, 7);
    tick();
    n = 0;
    for (int i = 0; i < 40 && o_state == 3'd1; i++) begin
      if (bus.o_imemReq) n++;
      tick();
    end
    chk("timeout req cycles", n, 16);
    chk("timeout fault", {29'b0, o_state}, 5);
    chk("fault req low", 32'(bus.o_imemReq), 0);
    apply(0, 0, 1, 0, 0, 7);
    tick();
    i_clearFault = 1'b0;
    chk("clearFault halt", 32'(o_halted), 1);

    // ack on the timeout cycle wins
    i_run = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    bus.i_imemAck = 1'b1;
    i_run = 1'b0;
    #1;
    chk("ack at timeout irWe", 32'(bus.o_irWe), 1);
    tick();
    chk("ack at timeout decode", 32'(o_state), 2);
    tick(); tick(); tick();
    chk("ack at timeout halt", 32'(o_state), 0);

    // counter wrap: 16 retires on 4-bit counters
    i_resetn = 1'b0;
    tick();
    i_resetn = 1'b1;
    apply(1, 0, 0, 1, 0, 1);
    r = 0;
    for (int i = 0; i < 200 && r < 16; i++) begin
      if (bus.o_retire) begin
        r++;
        if (r == 16) i_run = 1'b0;
      end
      tick();
    end
    chk("wrap retires", r, 16);
    chk("wrap instrCount", 32'(o_instrCount), 0);
    chk("wrap cycleCount", 32'(o_cycleCount), 0);
    chk("wrap halted", 32'(o_halted), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
